// File: rtl/count_sched.sv
`default_nettype none
// ============================================================================
// Module      : count_sched
// Description : Two-requester round-robin scheduler driving one shared
//               up/down counter. A granted job steps the counter len times in
//               the latched direction, then pulses done for its owner.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-high reset
//               req_i    - per-requester job request
//               dir_i    - per-requester direction (0 up, 1 down)
//               len_i    - per-requester step count, LEN_W bits each
//               clr_i    - clear counter (honoured in IDLE only)
//               gnt_o    - one-hot grant pulse
//               done_o   - one-hot job-complete pulse
//               busy_o   - state is not IDLE
//               owner_o  - most recently granted requester
//               count_o  - shared counter value
// Revision    : 1.0 - initial release
// ============================================================================
module count_sched #(
    parameter int CNT_W = 4,
    parameter int LEN_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_i,
    input  logic [1:0]         dir_i,
    input  logic [2*LEN_W-1:0] len_i,
    input  logic               clr_i,
    output logic [1:0]         gnt_o,
    output logic [1:0]         done_o,
    output logic               busy_o,
    output logic               owner_o,
    output logic [CNT_W-1:0]   count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] c_LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [LEN_W-1:0]   r_rem;
    logic               r_dir;
    logic               r_owner;
    logic               r_last;
    logic [1:0]         r_gnt;
    logic [1:0]         r_done;

    logic               w_winner;
    logic [LEN_W-1:0]   w_len_win;
    logic [1:0]         w_win_oh;
    logic [1:0]         w_own_oh;

    // On contention the requester that was not served last wins; otherwise
    // the single active requester wins (bit 1 set means requester 1).
    always_comb begin
        if (req_i == 2'b11) begin
            w_winner = ~r_last;
        end else begin
            w_winner = req_i[1];
        end
    end

    assign w_len_win = w_winner ? len_i[2*LEN_W-1:LEN_W] : len_i[LEN_W-1:0];
    assign w_win_oh  = w_winner ? 2'b10 : 2'b01;
    assign w_own_oh  = r_owner  ? 2'b10 : 2'b01;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_i != 2'b00) begin
                    w_state_nxt = (w_len_win != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (r_rem == c_LEN_ONE) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
        end else begin
            r_gnt  <= 2'b00;
            r_done <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (clr_i) begin
                        r_count <= '0;
                    end
                    if (req_i != 2'b00) begin
                        r_dir   <= dir_i[w_winner];
                        r_rem   <= w_len_win;
                        r_owner <= w_winner;
                        r_gnt   <= w_win_oh;
                    end
                end
                S_RUN: begin
                    r_count <= r_dir ? (r_count - c_CNT_ONE) : (r_count + c_CNT_ONE);
                    r_rem   <= r_rem - c_LEN_ONE;
                    if (r_rem == c_LEN_ONE) begin
                        r_done <= w_own_oh;
                    end
                end
                S_DONE: begin
                    r_last <= r_owner;
                    // A zero-length job reaches DONE while its grant pulse is
                    // still up, so its done pulse is pushed one cycle later to
                    // keep grant and done from overlapping.
                    if (r_gnt != 2'b00) begin
                        r_done <= w_own_oh;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt_o   = r_gnt;
    assign done_o  = r_done;
    assign busy_o  = (r_state != S_IDLE);
    assign owner_o = r_owner;
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_count_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_sched
// Description : Self-checking bench for count_sched. Stimulus pushes expected
//               grant and done events into queues; a monitor pops and compares
//               them whenever the DUT pulses gnt_o or done_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_i;
    logic [1:0] dir_i;
    logic [7:0] len_i;
    logic       clr_i;
    logic [1:0] gnt_o;
    logic [1:0] done_o;
    logic       busy_o;
    logic       owner_o;
    logic [3:0] count_o;

    count_sched #(.CNT_W(4), .LEN_W(4)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .dir_i   (dir_i),
        .len_i   (len_i),
        .clr_i   (clr_i),
        .gnt_o   (gnt_o),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .owner_o (owner_o),
        .count_o (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] bits;
        logic       own;
        logic [3:0] cnt;
        int         dly;
    } exp_t;

    exp_t gq[$];
    exp_t dq[$];

    int n_chk = 0;
    int n_err = 0;
    int n_gnt = 0;
    int cyc = 0;
    int last_gnt_cyc = 0;
    int last_done_cyc = 0;
    bit have_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic exp_g(input logic [1:0] b, input logic o);
        exp_t e;
        e.bits = b; e.own = o; e.cnt = '0; e.dly = 0;
        gq.push_back(e);
    endtask

    task automatic exp_d(input logic [1:0] b, input logic [3:0] c, input int d);
        exp_t e;
        e.bits = b; e.own = 1'b0; e.cnt = c; e.dly = d;
        dq.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            have_done = 0;
        end else begin
            cyc++;
            if (gnt_o != 2'b00 || done_o != 2'b00) begin
                chk("onehot_excl",
                    {31'b0, ((gnt_o != 2'b00) && (done_o != 2'b00)) ||
                            ($countones(gnt_o) > 1) || ($countones(done_o) > 1)}, 0);
            end
            if (gnt_o != 2'b00) begin
                n_gnt++;
                if (gq.size() == 0) begin
                    chk("unexpected_grant", gnt_o, 0);
                end else begin
                    e = gq.pop_front();
                    chk("gnt_o", gnt_o, e.bits);
                    chk("owner_o", owner_o, e.own);
                end
                if (have_done) begin
                    chk("idle_gap", {31'b0, (cyc - last_done_cyc) >= 2}, 1);
                end
                last_gnt_cyc = cyc;
            end
            if (done_o != 2'b00) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", done_o, 0);
                end else begin
                    e = dq.pop_front();
                    chk("done_o", done_o, e.bits);
                    chk("done_count", count_o, e.cnt);
                    chk("done_delay", cyc - last_gnt_cyc, e.dly);
                end
                last_done_cyc = cyc;
                have_done = 1;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("idle_timeout", 1, 0);
    endtask

    // Present a request for exactly one IDLE edge, then scramble dir/len so a
    // job that re-reads them mid-run would be caught.
    task automatic issue(input logic [1:0] r, input logic [1:0] d,
                         input logic [3:0] l0, input logic [3:0] l1, input logic c);
        wait_idle();
        req_i = r; dir_i = d; len_i = {l1, l0}; clr_i = c;
        @(posedge clk); #1;
        req_i = 2'b00; clr_i = 1'b0;
        dir_i = 2'($urandom); len_i = 8'($urandom);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_count", count_o, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_owner", owner_o, 0);
    endtask

    initial begin
        int e029[3];
        int base;
        int t;
        e029[0] = 0; e029[1] = 15; e029[2] = 14;
        rst = 1'b1; req_i = '0; dir_i = '0; len_i = '0; clr_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;

        // Basic up job, len 3 from 0.
        exp_g(2'b01, 1'b0); exp_d(2'b01, 4'd3, 3);
        issue(2'b01, 2'b00, 4'd3, 4'd0, 1'b0);
        wait_idle();
        @(posedge clk); #1;
        chk("busy_after", busy_o, 0);
        chk("count_hold", count_o, 3);

        // Up to 7, then a lone clear in IDLE.
        exp_g(2'b01, 1'b0); exp_d(2'b01, 4'd7, 4);
        issue(2'b01, 2'b00, 4'd4, 4'd0, 1'b0);
        wait_idle();
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        chk("clr_idle", count_o, 0);

        // Bring count to 1, then requester 1 counts down 3 through the wrap.
        exp_g(2'b01, 1'b0); exp_d(2'b01, 4'd1, 1);
        issue(2'b01, 2'b00, 4'd1, 4'd0, 1'b0);
        exp_g(2'b10, 1'b1); exp_d(2'b10, 4'd14, 3);
        issue(2'b10, 2'b10, 4'd0, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("down_wrap_step", count_o, e029[i]);
        end
        chk("owner_after_down", owner_o, 1);

        // Zero-length job: grant then done next cycle, count unchanged.
        exp_g(2'b01, 1'b0); exp_d(2'b01, 4'd14, 1);
        issue(2'b01, 2'b00, 4'd0, 4'd0, 1'b0);
        wait_idle();
        @(posedge clk); #1;
        chk("len0_count", count_o, 14);

        // Clear during RUN is ignored: 14 -> 15 -> 0 -> 1.
        exp_g(2'b10, 1'b1); exp_d(2'b10, 4'd1, 3);
        issue(2'b10, 2'b00, 4'd0, 4'd3, 1'b0);
        @(posedge clk); #1;
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;

        // Clear together with a grant: count restarts from 0, ends at 2.
        exp_g(2'b01, 1'b0); exp_d(2'b01, 4'd2, 2);
        issue(2'b01, 2'b00, 4'd2, 4'd0, 1'b1);
        wait_idle();

        // Fresh reset, both requesters held: order 0,1,0,1.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_g(2'b01, 1'b0); exp_d(2'b01, 4'd2, 2);
        exp_g(2'b10, 1'b1); exp_d(2'b10, 4'd4, 2);
        exp_g(2'b01, 1'b0); exp_d(2'b01, 4'd6, 2);
        exp_g(2'b10, 1'b1); exp_d(2'b10, 4'd8, 2);
        base = n_gnt;
        t = 0;
        req_i = 2'b11; dir_i = 2'b00; len_i = {4'd2, 4'd2};
        while (n_gnt < base + 4 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) chk("rr_timeout", 1, 0);
        req_i = 2'b00;
        wait_idle();

        // Reset at the 2nd step of a len-5 job: abort, no done pulse.
        exp_g(2'b01, 1'b0);
        issue(2'b01, 2'b00, 4'd5, 4'd0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        // New request after release is served normally.
        exp_g(2'b10, 1'b1); exp_d(2'b10, 4'd1, 1);
        issue(2'b10, 2'b00, 4'd0, 4'd1, 1'b0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("grants_left", gq.size(), 0);
        chk("dones_left", dq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 4, counter width in bits.
REQ-002 SHALL have parameter LEN_W, default 4, job step-count width in bits.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_i  in  2  per-requester job request; bit n belongs to requester n.
REQ-006 SHALL have port dir_i  in  2  per-requester direction, 0 = up, 1 = down.
REQ-007 SHALL have port len_i  in  2*LEN_W  per-requester step count; requester n uses bits [n*LEN_W +: LEN_W].
REQ-008 SHALL have port clr_i  in  1  request to clear the counter to 0.
REQ-009 SHALL have port gnt_o  out  2  one-hot grant pulse.
REQ-010 SHALL have port done_o  out  2  one-hot job-complete pulse.
REQ-011 SHALL have port busy_o  out  1  high whenever the state is not IDLE.
REQ-012 SHALL have port owner_o  out  1  index of the requester granted most recently.
REQ-013 SHALL have port count_o  out  CNT_W  current value of the shared counter register.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE, plus a CNT_W-bit counter, a LEN_W-bit remaining-steps register, latched dir, owner, and a round-robin last-served bit.
REQ-015 IDLE, req_i != 0 at an edge: SHALL pick the winner; SHALL latch its dir and len; SHALL set owner; SHALL assert gnt_o[winner] for exactly the next cycle; SHALL go to RUN if len != 0, else to DONE.
REQ-016 Arbitration: single requester -> that requester wins; both requesting -> the requester that is not last-served wins.
REQ-017 RUN, each edge: count SHALL step by 1 (up: +1, down: -1, modulo 2^CNT_W) and remaining SHALL decrement; when remaining == 1 the FSM SHALL go to DONE on that edge.
REQ-018 A job of length L granted at edge k SHALL produce count changes at edges k+1..k+L, done_o[owner] high for the cycle after edge k+L, and IDLE at edge k+L+1 (L=0: done_o high for the cycle after edge k+1).
REQ-019 On leaving DONE: last-served SHALL become owner; the earliest next grant SHALL be at the first edge in IDLE.
REQ-020 Wrap: up from 2^CNT_W-1 SHALL give 0; down from 0 SHALL give 2^CNT_W-1; there SHALL be no saturation or flag.
REQ-021 req_i, dir_i and len_i SHALL be ignored outside IDLE; a request withdrawn before its grant SHALL NOT be served; the latched dir and len SHALL NOT change mid-job.
REQ-022 clr_i in IDLE SHALL set count to 0 at that edge, including when a grant happens on the same edge; clr_i in RUN or DONE SHALL be ignored.
REQ-023 gnt_o and done_o SHALL never have more than one bit set and SHALL never both be high in the same cycle.
REQ-024 All outputs SHALL be driven from registers, except busy_o, which SHALL be decoded from the state register only.

Reset
REQ-025 rst high SHALL immediately force: state IDLE, count_o 0, gnt_o 0, done_o 0, busy_o 0, owner_o 0, last-served 1 (requester 0 favoured).
REQ-026 rst asserted mid-job SHALL abort the job without a done_o pulse; after release, the FSM SHALL accept new requests from the first edge.

Verification
REQ-027 After reset, req_i=01, dir=0, len=3 for one cycle -> gnt_o=01 for 1 cycle; count_o 1,2,3 on consecutive edges; done_o=01 for 1 cycle; busy_o low afterwards; count_o holds 3.
REQ-028 After reset, req_i=11 held, len0=2 up, len1=2 up -> grant order 0,1,0,1; gnt_o never 11; one IDLE cycle between each done_o and the next gnt_o.
REQ-029 count_o=1, requester 1 with dir=1, len=3 -> count_o 0,15,14; done_o=10; owner_o=1.
REQ-030 len=0 grant -> gnt_o pulse, then done_o pulse on the next cycle; count_o unchanged.
REQ-031 clr_i pulsed during RUN -> count unaffected; clr_i in IDLE with count_o=7 -> count_o 0 on the next edge; clr_i together with a grant -> count starts from 0.
REQ-032 rst pulsed at the 2nd step of a len=5 job -> all outputs reset at once; no done_o; a new request after release is granted normally.
